// File: rtl/companion_pkg.sv
// Shared types and constants for the companion stat scheduler.
// Holds the FSM encoding, the default stat count and the stat index names.
package companion_pkg;

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2
    } sched_state_e;

    localparam int DEFAULT_NUM_STATS = 3;

    localparam int STAT_HUNGER = 0;
    localparam int STAT_ENERGY = 1;
    localparam int STAT_JOY    = 2;

    // Counter width that never collapses to zero bits.
    function automatic int clog2_min1(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/companion_rr_arbiter.sv
// N-way round-robin arbiter: one-hot grant from a pending vector.
// The search starts at the stored pointer, which moves past each winner.
module companion_rr_arbiter
    import companion_pkg::*;
#(
    parameter int N     = DEFAULT_NUM_STATS,
    parameter int PTR_W = clog2_min1(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] pending,
    output logic [N-1:0] grant
);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] next_ptr;
    logic             found;
    int               idx;

    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (en && !found && pending[idx]) begin
                grant[idx] = 1'b1;
                next_ptr   = PTR_W'((idx + 1) % N);
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= next_ptr;
        end
    end

endmodule

// File: rtl/companion_stat_scheduler.sv
// Issues per-stat decay ticks from a shared prescaler and arbitrates user
// refresh requests onto one-hot refresh pulses; a stat never gets both at once.
module companion_stat_scheduler
    import companion_pkg::*;
#(
    parameter int NUM_STATS      = DEFAULT_NUM_STATS,
    parameter int TICK_PERIOD    = 1000,
    parameter int INTERVAL_W     = 8,
    parameter int COOLDOWN_TICKS = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                pause,
    input  logic                                cfg_we,
    input  logic [clog2_min1(NUM_STATS)-1:0]    cfg_sel,
    input  logic [INTERVAL_W-1:0]               cfg_data,
    input  logic [NUM_STATS-1:0]                req,
    output logic [NUM_STATS-1:0]                tick,
    output logic [NUM_STATS-1:0]                refresh,
    output logic [NUM_STATS-1:0]                req_ack,
    output logic [NUM_STATS-1:0]                req_reject,
    output logic                                running
);

    localparam int SEL_W = clog2_min1(NUM_STATS);
    localparam int PRE_W = clog2_min1(TICK_PERIOD);
    localparam int CD_W  = clog2_min1(COOLDOWN_TICKS + 1);

    sched_state_e           state;
    logic [PRE_W-1:0]       pre;
    logic                   base_tick;
    logic [INTERVAL_W-1:0]  interval [NUM_STATS];
    logic [INTERVAL_W-1:0]  cnt      [NUM_STATS];
    logic [CD_W-1:0]        cooldown [NUM_STATS];
    logic [NUM_STATS-1:0]   tick_due;
    logic [NUM_STATS-1:0]   pending;
    logic [NUM_STATS-1:0]   cd_busy;
    logic [NUM_STATS-1:0]   accept;
    logic [NUM_STATS-1:0]   eff_pending;
    logic [NUM_STATS-1:0]   grant;
    logic [NUM_STATS-1:0]   wrap;
    logic [NUM_STATS-1:0]   tick_emit;

    // Request handshake: req[i] is a one-cycle pulse from the UI. Exactly one
    // cycle later it is answered by req_reject[i] (stat cooling down) or it is
    // held pending until a grant, signalled by refresh[i] together with req_ack[i].
    // Nothing is answered while STOPPED. Repeats while pending merge.
    assign running   = (state == ST_RUNNING);
    assign base_tick = running && (pre == PRE_W'(TICK_PERIOD - 1));
    assign req_ack   = refresh;

    always_comb begin
        cd_busy   = '0;
        wrap      = '0;
        tick_emit = '0;
        for (int i = 0; i < NUM_STATS; i++) begin
            cd_busy[i]   = (cooldown[i] != '0);
            wrap[i]      = base_tick && (interval[i] != '0) &&
                           (cnt[i] == interval[i] - INTERVAL_W'(1));
            // A grant this cycle pushes the decay pulse back by one cycle.
            tick_emit[i] = tick_due[i] && running && !grant[i];
        end
        accept      = (state != ST_STOPPED) ? (req & ~cd_busy) : '0;
        eff_pending = pending | accept;
    end

    companion_rr_arbiter #(
        .N (NUM_STATS)
    ) u_arbiter (
        .clk     (clk),
        .rst     (rst),
        .en      (running),
        .pending (eff_pending),
        .grant   (grant)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_STOPPED;
        end else begin
            case (state)
                ST_STOPPED: if (start)  state <= ST_RUNNING;
                ST_RUNNING: if (pause)  state <= ST_PAUSED;
                ST_PAUSED:  if (!pause) state <= ST_RUNNING;
                default:                state <= ST_STOPPED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre        <= '0;
            tick_due   <= '0;
            pending    <= '0;
            tick       <= '0;
            refresh    <= '0;
            req_reject <= '0;
            for (int i = 0; i < NUM_STATS; i++) begin
                interval[i] <= '0;
                cnt[i]      <= '0;
                cooldown[i] <= '0;
            end
        end else begin
            if (running) begin
                pre <= base_tick ? '0 : pre + PRE_W'(1);
            end
            tick_due   <= (tick_due & ~tick_emit) | wrap;
            pending    <= (state == ST_STOPPED) ? '0 : (eff_pending & ~grant);
            tick       <= tick_emit;
            refresh    <= grant;
            req_reject <= (state != ST_STOPPED) ? (req & cd_busy) : '0;
            for (int i = 0; i < NUM_STATS; i++) begin
                if (cfg_we && (cfg_sel == SEL_W'(i))) begin
                    interval[i] <= cfg_data;
                    cnt[i]      <= '0;
                end else if (wrap[i]) begin
                    cnt[i] <= '0;
                end else if (base_tick && (interval[i] != '0)) begin
                    cnt[i] <= cnt[i] + INTERVAL_W'(1);
                end
                if (grant[i]) begin
                    cooldown[i] <= CD_W'(COOLDOWN_TICKS);
                end else if (base_tick && cd_busy[i]) begin
                    cooldown[i] <= cooldown[i] - CD_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_companion_stat_scheduler.sv
// Directed bench for companion_stat_scheduler with TICK_PERIOD=4, three stats,
// cooldown of 2 base ticks and decay intervals 2, 3, 0.
module tb_companion_stat_scheduler;
  import companion_pkg::*;

  localparam int S_STOP  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;

  logic       clk;
  logic       rst;
  logic       start;
  logic       pause;
  logic       cfg_we;
  logic [1:0] cfg_sel;
  logic [7:0] cfg_data;
  logic [2:0] req;
  logic [2:0] tick;
  logic [2:0] refresh;
  logic [2:0] req_ack;
  logic [2:0] req_reject;
  logic       running;

  int checks;
  int errors;
  int act;
  int exp_state;
  bit post_reset;

  companion_stat_scheduler #(
    .NUM_STATS      (3),
    .TICK_PERIOD    (4),
    .INTERVAL_W     (8),
    .COOLDOWN_TICKS (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pause      (pause),
    .cfg_we     (cfg_we),
    .cfg_sel    (cfg_sel),
    .cfg_data   (cfg_data),
    .req        (req),
    .tick       (tick),
    .refresh    (refresh),
    .req_ack    (req_ack),
    .req_reject (req_reject),
    .running    (running)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s act=%0d got=%0h expected=%0h", tag, act, got, exp);
    end
  endtask

  // Expected decay pulses by running-cycle index; stat 1 is deferred at 61
  // by the refresh granted that cycle, stat 2 is enabled mid-run at 70.
  function automatic logic [2:0] exp_tick(input int a);
    logic [2:0] t;
    t = 3'b000;
    if (!post_reset) begin
      t[STAT_HUNGER] = (a >= 9) && ((a - 9) % 8 == 0);
      t[STAT_ENERGY] = ((a >= 13) && ((a - 13) % 12 == 0) && (a != 61)) || (a == 62);
      t[STAT_JOY]    = (a >= 73) && ((a - 73) % 4 == 0);
    end
    return t;
  endfunction

  // driver: one clock edge, then compare every output and clear pulse inputs
  task automatic step(input logic [2:0] e_ref, input logic [2:0] e_rej);
    logic       run_before;
    logic [2:0] e_tick;
    run_before = rst && (exp_state == S_RUN);
    @(posedge clk);
    #1;
    if (run_before) act++;
    if (rst) begin
      case (exp_state)
        S_STOP:  if (start)  exp_state = S_RUN;
        S_RUN:   if (pause)  exp_state = S_PAUSE;
        S_PAUSE: if (!pause) exp_state = S_RUN;
        default: exp_state = S_STOP;
      endcase
    end
    e_tick = run_before ? exp_tick(act) : 3'b000;
    check_val("tick", 32'(tick), 32'(e_tick));
    check_val("refresh", 32'(refresh), 32'(e_ref));
    check_val("req_ack", 32'(req_ack), 32'(e_ref));
    check_val("req_reject", 32'(req_reject), 32'(e_rej));
    check_val("running", 32'(running), (exp_state == S_RUN) ? 32'd1 : 32'd0);
    req    = 3'b000;
    start  = 1'b0;
    cfg_we = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [7:0] data);
    cfg_we   = 1'b1;
    cfg_sel  = sel;
    cfg_data = data;
    step(3'b000, 3'b000);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    act        = 0;
    exp_state  = S_STOP;
    post_reset = 1'b0;
    rst        = 1'b0;
    start      = 1'b0;
    pause      = 1'b0;
    cfg_we     = 1'b0;
    cfg_sel    = 2'd0;
    cfg_data   = 8'd0;
    req        = 3'b000;

    // reset state
    step(3'b000, 3'b000);
    step(3'b000, 3'b000);
    rst = 1'b1;

    // intervals 2,3,0; out-of-range select must not disturb anything
    cfg_write(2'd0, 8'd2);
    cfg_write(2'd1, 8'd3);
    cfg_write(2'd2, 8'd0);
    cfg_write(2'd3, 8'd5);

    // requests in STOPPED are dropped
    req = 3'b010;
    step(3'b000, 3'b000);

    start = 1'b1;
    step(3'b000, 3'b000);

    // free-running decay, extra start pulse at act 20 is ignored
    for (int i = 1; i <= 43; i++) begin
      if (i == 20) start = 1'b1;
      step(3'b000, 3'b000);
    end

    // all three requested at once: round-robin over three cycles
    req = 3'b111;
    step(3'b001, 3'b000);
    step(3'b010, 3'b000);
    step(3'b100, 3'b000);

    // stat 0 re-requested inside its cooldown
    req = 3'b001;
    step(3'b000, 3'b001);
    repeat (5) step(3'b000, 3'b000);
    req = 3'b001;
    step(3'b001, 3'b000);
    repeat (7) step(3'b000, 3'b000);

    // request on the cycle stat 1 tick is due: refresh now, tick next cycle
    req = 3'b010;
    step(3'b010, 3'b000);
    step(3'b000, 3'b000);
    step(3'b000, 3'b000);

    // pause for 20 clocks with a request pended during the pause
    pause = 1'b1;
    step(3'b000, 3'b000);
    for (int i = 0; i < 19; i++) begin
      if (i == 4) req = 3'b100;
      step(3'b000, 3'b000);
    end
    pause = 1'b0;
    step(3'b000, 3'b000);
    step(3'b100, 3'b000);

    // enable stat 2 decay mid-run with interval 1
    repeat (4) step(3'b000, 3'b000);
    cfg_write(2'd2, 8'd1);
    repeat (8) step(3'b000, 3'b000);

    // asynchronous reset while a refresh is on the outputs
    req = 3'b001;
    step(3'b001, 3'b000);
    rst = 1'b0;
    #1;
    check_val("rst_tick", 32'(tick), 32'd0);
    check_val("rst_refresh", 32'(refresh), 32'd0);
    check_val("rst_req_ack", 32'(req_ack), 32'd0);
    check_val("rst_req_reject", 32'(req_reject), 32'd0);
    check_val("rst_running", 32'(running), 32'd0);
    exp_state  = S_STOP;
    post_reset = 1'b1;
    step(3'b000, 3'b000);
    rst = 1'b1;

    // after reset: dropped in STOPPED, pointer back at 0, cooldown cleared, no decay
    req = 3'b111;
    step(3'b000, 3'b000);
    start = 1'b1;
    step(3'b000, 3'b000);
    repeat (3) step(3'b000, 3'b000);
    req = 3'b111;
    step(3'b001, 3'b000);
    step(3'b010, 3'b000);
    step(3'b100, 3'b000);
    repeat (12) step(3'b000, 3'b000);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
